// File: rtl/axi4w_pkg.sv
// Shared constants for the axi4w burst writer: FSM encoding and AXI4 field values.
package axi4w_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle = 3'd0;
  localparam state_t StAw   = 3'd1;
  localparam state_t StW    = 3'd2;
  localparam state_t StB    = 3'd3;
  localparam state_t StDone = 3'd4;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_8B    = 3'd3;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam int unsigned AXI_4K_BEATS  = 512;

endpackage

// File: rtl/axi4w_burst_len.sv
// Burst length for the next INCR burst: min(remaining, MAX_BURST, beats left in the 4 KiB page).
module axi4w_burst_len
  import axi4w_pkg::*;
#(
  parameter int unsigned MAX_BURST = 16
) (
  input  logic [15:0] remaining,
  input  logic [8:0]  page_beat,
  output logic [15:0] blen
);

  localparam logic [15:0] MaxBurst = 16'(MAX_BURST);

  logic [15:0] to_4k;

  // page_beat is the 8-byte beat index within the page, so this is never zero
  assign to_4k = 16'(AXI_4K_BEATS) - {7'd0, page_beat};

  always_comb begin
    blen = remaining;
    if (blen > MaxBurst) blen = MaxBurst;
    if (blen > to_4k)    blen = to_4k;
  end

endmodule

// File: rtl/axi4w_burst_writer.sv
// AXI4 write master: splits a (address, beat count) command into INCR bursts, one outstanding.
module axi4w_burst_writer
  import axi4w_pkg::*;
#(
  parameter int unsigned MAX_BURST = 16,
  parameter logic [3:0]  AXI_ID    = 4'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic [15:0] cmd_beats,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [63:0] s_data,
  input  logic [7:0]  s_strb,
  output logic        done_valid,
  output logic        done_err,
  output logic [3:0]  m_axi_awid,
  output logic [31:0] m_axi_awaddr,
  output logic [7:0]  m_axi_awlen,
  output logic [2:0]  m_axi_awsize,
  output logic [1:0]  m_axi_awburst,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [63:0] m_axi_wdata,
  output logic [7:0]  m_axi_wstrb,
  output logic        m_axi_wlast,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [3:0]  m_axi_bid,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready
);

  state_t      state_q, state_d;
  logic [31:0] cur_addr_q, cur_addr_d;
  logic [15:0] remaining_q, remaining_d;
  logic [7:0]  awlen_q, awlen_d;
  logic [7:0]  beat_cnt_q, beat_cnt_d;
  logic        err_q, err_d;

  logic [31:0] cmd_addr_al;
  logic [15:0] blen_q;
  logic [31:0] nxt_addr;
  logic [15:0] nxt_rem;
  logic [15:0] len_rem;
  logic [8:0]  len_page;
  logic [15:0] blen;
  logic        w_hs;

  assign cmd_addr_al = cmd_addr & 32'hFFFF_FFF8;
  assign blen_q      = {8'd0, awlen_q} + 16'd1;
  assign nxt_addr    = cur_addr_q + {13'd0, blen_q, 3'b000};
  assign nxt_rem     = remaining_q - blen_q;

  // The next burst length is sized from the command in IDLE, else from post-burst counters in B
  assign len_rem  = (state_q == StIdle) ? cmd_beats : nxt_rem;
  assign len_page = (state_q == StIdle) ? cmd_addr_al[11:3] : nxt_addr[11:3];

  axi4w_burst_len #(
    .MAX_BURST (MAX_BURST)
  ) u_burst_len (
    .remaining (len_rem),
    .page_beat (len_page),
    .blen      (blen)
  );

  assign w_hs = (state_q == StW) && s_valid && m_axi_wready;

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    awlen_d     = awlen_q;
    beat_cnt_d  = beat_cnt_q;
    err_d       = err_q;
    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          cur_addr_d  = cmd_addr_al;
          remaining_d = cmd_beats;
          err_d       = 1'b0;
          beat_cnt_d  = '0;
          if (cmd_beats == 16'd0) begin
            state_d = StDone;
          end else begin
            state_d = StAw;
            awlen_d = 8'(blen - 16'd1);
          end
        end
      end
      StAw: begin
        if (m_axi_awready) state_d = StW;
      end
      StW: begin
        if (w_hs) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (m_axi_wlast) state_d = StB;
        end
      end
      StB: begin
        if (m_axi_bvalid) begin
          err_d       = err_q | (m_axi_bresp != AXI_RESP_OKAY) | (m_axi_bid != AXI_ID);
          cur_addr_d  = nxt_addr;
          remaining_d = nxt_rem;
          beat_cnt_d  = '0;
          if (nxt_rem == 16'd0) begin
            state_d = StDone;
          end else begin
            state_d = StAw;
            awlen_d = 8'(blen - 16'd1);
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      awlen_q     <= '0;
      beat_cnt_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      awlen_q     <= awlen_d;
      beat_cnt_q  <= beat_cnt_d;
      err_q       <= err_d;
    end
  end

  assign cmd_ready     = (state_q == StIdle);
  assign done_valid    = (state_q == StDone);
  assign done_err      = (state_q == StDone) && err_q;

  assign m_axi_awid    = AXI_ID;
  assign m_axi_awaddr  = cur_addr_q;
  assign m_axi_awlen   = awlen_q;
  assign m_axi_awsize  = AXI_SIZE_8B;
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_awvalid = (state_q == StAw);

  assign m_axi_wdata   = s_data;
  assign m_axi_wstrb   = s_strb;
  assign m_axi_wvalid  = (state_q == StW) && s_valid;
  assign m_axi_wlast   = (state_q == StW) && (beat_cnt_q == awlen_q);
  assign s_ready       = (state_q == StW) && m_axi_wready;

  assign m_axi_bready  = (state_q == StB);

endmodule

// File: tb/tb_axi4w_burst_writer.sv
// Bench for axi4w_burst_writer: burst-length table plus a randomized AXI slave and burst model.
module tb_axi4w_burst_writer;

  localparam int MB = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_beats;
  logic        s_valid, s_ready;
  logic [63:0] s_data;
  logic [7:0]  s_strb;
  logic        done_valid, done_err;
  logic [3:0]  m_axi_awid;
  logic [31:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awvalid, m_axi_awready;
  logic [63:0] m_axi_wdata;
  logic [7:0]  m_axi_wstrb;
  logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [3:0]  m_axi_bid;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid, m_axi_bready;

  logic [15:0] len_rem;
  logic [8:0]  len_page;
  logic [15:0] len16, len1;

  always #5 clk = ~clk;

  axi4w_burst_writer #(.MAX_BURST(MB), .AXI_ID(4'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_strb(s_strb),
    .done_valid(done_valid), .done_err(done_err),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready)
  );

  axi4w_burst_len #(.MAX_BURST(16)) u_len16 (
    .remaining(len_rem), .page_beat(len_page), .blen(len16)
  );
  axi4w_burst_len #(.MAX_BURST(1)) u_len1 (
    .remaining(len_rem), .page_beat(len_page), .blen(len1)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic int ref_blen(input int rem, input int off, input int mb);
    int n, pg;
    pg = (4096 - off) / 8;
    n = rem;
    if (n > mb) n = mb;
    if (n > pg) n = pg;
    return n;
  endfunction

  typedef struct {
    logic [15:0] rem;
    logic [11:0] off;
    logic [15:0] exp16;
  } len_vec_t;

  // Model and slave state
  logic [31:0] exp_addr[$];
  int          exp_len[$];
  logic [63:0] dat[$];
  logic [7:0]  stb[$];
  int nb, aw_idx, w_burst, w_beat, w_total, b_idx, done_cnt, aw_seen, s_idx;
  int err_burst, b_wait, cyc, acc_cyc, done_cyc, first_aw_cyc;
  bit b_pending, stall, exp_err, accepted, err_by_bid, hs_s, hs_b;
  bit prev_aw_stall, prev_w_stall, prev_b_hs, prev_done;
  logic [31:0] p_awaddr;
  logic [7:0]  p_awlen;
  logic [63:0] p_wdata;
  logic        p_wlast;

  task automatic monitor();
    if (prev_aw_stall) begin
      chk("aw_valid_hold", m_axi_awvalid, 1);
      chk("aw_addr_hold", m_axi_awaddr, p_awaddr);
      chk("aw_len_hold", m_axi_awlen, p_awlen);
    end
    if (prev_w_stall) begin
      chk("w_valid_hold", m_axi_wvalid, 1);
      chk("w_data_hold", m_axi_wdata, p_wdata);
      chk("w_last_hold", m_axi_wlast, p_wlast);
    end
    if (prev_b_hs) begin
      if (b_idx < nb) chk("b_to_aw_latency", m_axi_awvalid, 1);
      else chk("b_to_done_latency", done_valid, 1);
    end
    if (prev_done) begin
      chk("done_pulse_width", done_valid, 0);
      chk("cmd_ready_return", cmd_ready, 1);
    end
    if (cmd_valid && cmd_ready && !accepted) begin
      accepted = 1;
      acc_cyc = cyc;
    end
    // W side is judged before this cycle's AW handshake is counted
    if (m_axi_wvalid) chk("w_before_aw", aw_idx > w_burst, 1);
    if (!(aw_idx > w_burst)) chk("s_ready_closed", s_ready, 0);
    hs_s = s_valid && s_ready;
    if (m_axi_wvalid && m_axi_wready) begin
      chk("s_ready_on_w_hs", s_ready, 1);
      if (w_total >= dat.size()) chk("w_extra", w_total + 1, dat.size());
      else if (w_burst >= nb) chk("w_burst_extra", w_burst + 1, nb);
      else begin
        chk("w_data", m_axi_wdata, dat[w_total]);
        chk("w_strb", m_axi_wstrb, stb[w_total]);
        chk("w_last", m_axi_wlast, w_beat == exp_len[w_burst] - 1);
      end
      w_beat++;
      w_total++;
      if (w_burst < nb && w_beat == exp_len[w_burst]) begin
        w_burst++;
        w_beat = 0;
        b_pending = 1;
        b_wait = stall ? $urandom_range(0, 3) : 0;
      end
    end
    if (m_axi_awvalid) begin
      aw_seen++;
      if (first_aw_cyc < 0) first_aw_cyc = cyc;
    end
    if (m_axi_awvalid && m_axi_awready) begin
      if (aw_idx < nb) begin
        chk("aw_addr", m_axi_awaddr, exp_addr[aw_idx]);
        chk("aw_len", m_axi_awlen, exp_len[aw_idx] - 1);
        chk("aw_size", m_axi_awsize, 3);
        chk("aw_burst", m_axi_awburst, 1);
        chk("aw_id", m_axi_awid, 0);
      end else chk("aw_extra", aw_idx + 1, nb);
      aw_idx++;
    end
    hs_b = m_axi_bvalid && m_axi_bready;
    if (hs_b) b_idx++;
    if (done_valid) begin
      done_cnt++;
      done_cyc = cyc;
      chk("done_err", done_err, exp_err);
      chk("done_after_all_b", b_idx, nb);
    end
    prev_aw_stall = m_axi_awvalid && !m_axi_awready;
    p_awaddr = m_axi_awaddr;
    p_awlen = m_axi_awlen;
    prev_w_stall = m_axi_wvalid && !m_axi_wready;
    p_wdata = m_axi_wdata;
    p_wlast = m_axi_wlast;
    prev_b_hs = hs_b;
    prev_done = done_valid;
  endtask

  task automatic drive();
    if (accepted) cmd_valid = 0;
    m_axi_awready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    m_axi_wready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    if (hs_s) s_idx++;
    if (!(s_valid && !hs_s)) begin
      if (s_idx < dat.size()) begin
        s_valid = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
        s_data = dat[s_idx];
        s_strb = stb[s_idx];
      end else s_valid = 0;
    end
    if (hs_b) begin
      m_axi_bvalid = 0;
      m_axi_bresp = 2'b00;
      m_axi_bid = 4'h0;
    end
    if (b_pending && !m_axi_bvalid) begin
      if (b_wait == 0) begin
        m_axi_bvalid = 1;
        b_pending = 0;
        m_axi_bresp = (b_idx == err_burst && !err_by_bid) ? 2'b10 : 2'b00;
        m_axi_bid = (b_idx == err_burst && err_by_bid) ? 4'h5 : 4'h0;
      end else b_wait--;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    cyc++;
    monitor();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic run_cmd(input logic [31:0] addr, input int beats, input int ebst, input bit bid_err,
                         input bit stl, input int abort_beat);
    logic [31:0] cur;
    int rem, n;
    bit aborted;
    exp_addr.delete(); exp_len.delete(); dat.delete(); stb.delete();
    cur = addr & 32'hFFFF_FFF8;
    rem = beats;
    while (rem > 0) begin
      n = ref_blen(rem, int'(cur[11:0]), MB);
      exp_addr.push_back(cur);
      exp_len.push_back(n);
      cur = cur + 32'(n * 8);
      rem -= n;
    end
    for (int i = 0; i < beats; i++) begin
      dat.push_back({$urandom, $urandom});
      stb.push_back(8'($urandom));
    end
    nb = exp_addr.size();
    aw_idx = 0; w_burst = 0; w_beat = 0; w_total = 0; b_idx = 0; done_cnt = 0; aw_seen = 0;
    s_idx = 0; b_pending = 0; accepted = 0;
    acc_cyc = -1; done_cyc = -1; first_aw_cyc = -1;
    err_burst = ebst; err_by_bid = bid_err; stall = stl;
    exp_err = (ebst >= 0 && ebst < nb);
    cmd_addr = addr; cmd_beats = 16'(beats); cmd_valid = 1;
    n = 0;
    aborted = 0;
    while (done_cnt == 0 && n < 3000 && !aborted) begin
      cycle();
      n++;
      if (abort_beat > 0 && w_total == abort_beat - 1) aborted = 1;
    end
    if (!aborted) begin
      if (done_cnt == 0) chk("timeout_done", done_cnt, 1);
      else begin
        cycle();
        cycle();
        chk("done_count", done_cnt, 1);
        chk("aw_count", aw_idx, nb);
        chk("w_beat_count", w_total, beats);
        chk("b_count", b_idx, nb);
        if (beats == 0) begin
          chk("zero_no_aw", aw_seen, 0);
          chk("zero_done_latency", done_cyc - acc_cyc, 1);
        end else chk("aw_latency", first_aw_cyc - acc_cyc, 1);
      end
    end
  endtask

  initial begin
    len_vec_t vec[10];
    int r, o;
    vec = '{
      '{16'd16,    12'h000, 16'd16},
      '{16'd8,     12'hFF0, 16'd2},
      '{16'd1,     12'h000, 16'd1},
      '{16'd100,   12'hFF8, 16'd1},
      '{16'd40,    12'h100, 16'd16},
      '{16'd0,     12'h000, 16'd0},
      '{16'd65535, 12'h000, 16'd16},
      '{16'd5,     12'hFE0, 16'd4},
      '{16'd3,     12'h800, 16'd3},
      '{16'd20,    12'hF80, 16'd16}
    };
    rst_n = 0; cmd_valid = 0; cmd_addr = '0; cmd_beats = '0;
    s_valid = 0; s_data = '0; s_strb = '0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 2'b00; m_axi_bid = 4'h0;
    cyc = 0; nb = 0; aw_idx = 0; w_burst = 0; b_idx = 0;

    for (int i = 0; i < 10; i++) begin
      len_rem = vec[i].rem;
      len_page = vec[i].off[11:3];
      #1;
      chk("blen16_table", len16, vec[i].exp16);
      chk("blen1_table", len1, (vec[i].rem == 0) ? 16'd0 : 16'd1);
    end
    for (int i = 0; i < 20; i++) begin
      r = $urandom_range(0, 600);
      o = 8 * $urandom_range(0, 511);
      len_rem = 16'(r);
      len_page = 9'(o / 8);
      #1;
      chk("blen16_rand", len16, ref_blen(r, o, 16));
      chk("blen1_rand", len1, ref_blen(r, o, 1));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_awvalid", m_axi_awvalid, 0);
    chk("rst_wvalid", m_axi_wvalid, 0);
    chk("rst_bready", m_axi_bready, 0);
    chk("rst_done", {done_valid, done_err}, 0);
    chk("rst_awaddr", m_axi_awaddr, 0);
    chk("rst_awlen", m_axi_awlen, 0);
    chk("rst_awsize", m_axi_awsize, 3);
    chk("rst_awburst", m_axi_awburst, 1);
    chk("rst_awid", m_axi_awid, 0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

    run_cmd(32'h0000_1000, 16, -1, 0, 0, 0);
    run_cmd(32'h0000_0FF0, 8, -1, 0, 0, 0);
    run_cmd(32'h0000_2000, 40, -1, 0, 1, 0);
    run_cmd(32'h0000_3000, 20, 1, 0, 1, 0);
    run_cmd(32'h0000_3000, 5, -1, 0, 1, 0);
    run_cmd(32'h0000_7000, 0, -1, 0, 0, 0);
    run_cmd(32'h0000_0FF8, 3, -1, 0, 0, 0);
    run_cmd(32'h0000_4005, 2, -1, 0, 0, 0);
    run_cmd(32'hFFFF_FFF0, 4, -1, 0, 1, 0);
    run_cmd(32'h0000_8000, 4, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      run_cmd($urandom & 32'hFFFF_FFF8, $urandom_range(1, 70),
              ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : -1,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
    end

    // Reset while the fifth of sixteen beats is on the bus
    run_cmd(32'h0000_5000, 16, -1, 0, 0, 5);
    chk("pre_reset_wvalid", m_axi_wvalid, 1);
    rst_n = 0;
    #1;
    chk("mid_rst_awvalid", m_axi_awvalid, 0);
    chk("mid_rst_wvalid", m_axi_wvalid, 0);
    chk("mid_rst_s_ready", s_ready, 0);
    chk("mid_rst_bready", m_axi_bready, 0);
    chk("mid_rst_done", done_valid, 0);
    chk("mid_rst_awaddr", m_axi_awaddr, 0);
    s_valid = 0; m_axi_bvalid = 0; cmd_valid = 0; b_pending = 0;
    prev_aw_stall = 0; prev_w_stall = 0; prev_b_hs = 0; prev_done = 0;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    chk("post_rst_cmd_ready", cmd_ready, 1);
    run_cmd(32'h0000_6000, 16, -1, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
